// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
// Register map, CTRL bit positions and FSM state encoding.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        FIN
    } state_t;

    localparam logic [15:0] ADDRBASE = 16'h0030;

    localparam logic [2:0] CTRL_OFS = 3'd0;
    localparam logic [2:0] SRC_OFS  = 3'd2;
    localparam logic [2:0] DST_OFS  = 3'd4;
    localparam logic [2:0] CNT_OFS  = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_DONE   = 3;
    localparam int CTRL_ABORT  = 4;

    function automatic logic in_window(input logic [15:0] a);
        return a[15:3] == ADDRBASE[15:3];
    endfunction

    function automatic logic [15:0] byte_merge(
        input logic [15:0] old,
        input logic [15:0] wdata,
        input logic [1:0]  be
    );
        return {be[1] ? wdata[15:8] : old[15:8],
                be[0] ? wdata[7:0]  : old[7:0]};
    endfunction

endpackage

// File: rtl/dma_controller.sv
// Memory-mapped DMA engine: register window responder plus bus
// master copying 16-bit words from SRC to DST, COUNT words long.
import dma_pkg::*;

module dma_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_read_addr,
    output logic [15:0] reg_read_data,
    input  logic [15:0] reg_write_addr,
    input  logic [15:0] reg_write_data,
    input  logic [1:0]  reg_write_en,
    output logic        m_req,
    input  logic        m_grant,
    output logic [15:0] m_read_addr,
    input  logic [15:0] m_read_data,
    output logic [15:0] m_write_addr,
    output logic [15:0] m_write_data,
    output logic [1:0]  m_write_en,
    output logic        done_int
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] count;
    logic        irq_en;
    logic        done;
    logic        abort_pend;
    logic        busy;

    logic        wr_hit;
    logic [2:0]  wr_ofs;
    logic        wr_ctrl;
    logic        start_req;
    logic        launch;
    logic        rd_hit;
    logic [2:0]  rd_ofs;
    logic [15:0] rdata;
    logic        unused_addr_lsb;

    assign busy     = (state != IDLE);
    assign done_int = done & irq_en;

    assign wr_hit    = in_window(reg_write_addr) && (reg_write_en != 2'b00);
    assign wr_ofs    = {reg_write_addr[2:1], 1'b0};
    assign wr_ctrl   = wr_hit && (wr_ofs == CTRL_OFS) && reg_write_en[0];
    assign start_req = wr_ctrl && reg_write_data[CTRL_START];
    assign launch    = start_req && !busy && (count != 16'd0);

    assign rd_hit = in_window(reg_read_addr);
    assign rd_ofs = {reg_read_addr[2:1], 1'b0};

    assign unused_addr_lsb = ^{reg_read_addr[0], reg_write_addr[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        m_req        = 1'b0;
        m_read_addr  = 16'h0000;
        m_write_addr = 16'h0000;
        m_write_data = 16'h0000;
        m_write_en   = 2'b00;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                m_req = 1'b1;
                if (m_grant) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                m_req       = 1'b1;
                m_read_addr = src;
                state_nxt   = WR;
            end
            WR: begin
                m_req        = 1'b1;
                m_write_addr = dst;
                m_write_data = m_read_data;
                m_write_en   = 2'b11;
                // grant loss and abort only act here, between words
                if (count == 16'd1 || abort_pend) begin
                    state_nxt = FIN;
                end else if (!m_grant) begin
                    state_nxt = REQ;
                end else begin
                    state_nxt = RD;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata = 16'h0000;
        if (rd_hit) begin
            case (rd_ofs)
                CTRL_OFS: begin
                    rdata[CTRL_BUSY]   = busy;
                    rdata[CTRL_IRQ_EN] = irq_en;
                    rdata[CTRL_DONE]   = done;
                end
                SRC_OFS: rdata = src;
                DST_OFS: rdata = dst;
                CNT_OFS: rdata = count;
                default: rdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src           <= 16'h0000;
            dst           <= 16'h0000;
            count         <= 16'h0000;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            abort_pend    <= 1'b0;
            reg_read_data <= 16'h0000;
        end else begin
            reg_read_data <= rdata;

            if (wr_hit && !busy) begin
                case (wr_ofs)
                    SRC_OFS: src <= byte_merge(src, reg_write_data, reg_write_en)
                                    & 16'hFFFE;
                    DST_OFS: dst <= byte_merge(dst, reg_write_data, reg_write_en)
                                    & 16'hFFFE;
                    CNT_OFS: count <= byte_merge(count, reg_write_data, reg_write_en);
                    default: ;
                endcase
            end

            if (state == WR) begin
                src   <= src + 16'd2;
                dst   <= dst + 16'd2;
                count <= count - 16'd1;
            end

            if (wr_ctrl) begin
                irq_en <= reg_write_data[CTRL_IRQ_EN];
            end

            // completion beats a same-cycle done-clear
            if (state == FIN || (start_req && !busy && count == 16'd0)) begin
                done <= 1'b1;
            end else if (wr_ctrl && reg_write_data[CTRL_DONE]) begin
                done <= 1'b0;
            end

            if (state == FIN) begin
                abort_pend <= 1'b0;
            end else if (busy && wr_ctrl && reg_write_data[CTRL_ABORT]) begin
                abort_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Randomized self-checking bench for dma_controller against a
// word-list reference model of the copy and the register map.
module tb_dma_controller;

    localparam logic [15:0] A_CTRL = 16'h0030;
    localparam logic [15:0] A_SRC  = 16'h0032;
    localparam logic [15:0] A_DST  = 16'h0034;
    localparam logic [15:0] A_CNT  = 16'h0036;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] reg_read_addr;
    logic [15:0] reg_read_data;
    logic [15:0] reg_write_addr;
    logic [15:0] reg_write_data;
    logic [1:0]  reg_write_en;
    logic        m_req;
    logic        m_grant;
    logic [15:0] m_read_addr;
    logic [15:0] m_read_data = 16'h0000;
    logic [15:0] m_write_addr;
    logic [15:0] m_write_data;
    logic [1:0]  m_write_en;
    logic        done_int;

    int errors = 0;
    int checks = 0;
    logic rgrant = 1'b0;

    logic [15:0] mem [0:32767];
    logic [15:0] log_addr [$];
    logic [15:0] log_data [$];

    dma_controller dut (
        .clk            (clk),
        .reset          (reset),
        .reg_read_addr  (reg_read_addr),
        .reg_read_data  (reg_read_data),
        .reg_write_addr (reg_write_addr),
        .reg_write_data (reg_write_data),
        .reg_write_en   (reg_write_en),
        .m_req          (m_req),
        .m_grant        (m_grant),
        .m_read_addr    (m_read_addr),
        .m_read_data    (m_read_data),
        .m_write_addr   (m_write_addr),
        .m_write_data   (m_write_data),
        .m_write_en     (m_write_en),
        .done_int       (done_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) m_read_data <= mem[m_read_addr[15:1]];

    always @(negedge clk) begin
        if (m_write_en == 2'b11) begin
            log_addr.push_back(m_write_addr);
            log_data.push_back(m_write_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] be = 2'b11);
        @(negedge clk);
        reg_write_addr = a;
        reg_write_data = d;
        reg_write_en   = be;
        @(negedge clk);
        reg_write_en   = 2'b00;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input logic [15:0] exp);
        @(negedge clk);
        reg_read_addr = a;
        @(negedge clk);
        check(tag, 32'(reg_read_data), 32'(exp));
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!done_int && n < budget) begin
            @(negedge clk);
            if (rgrant) m_grant = 1'($urandom_range(0, 1));
            n++;
        end
        m_grant = 1'b1;
        check("irq_timeout", 32'(done_int), 32'd1);
    endtask

    task automatic wait_writes(input int nw, input int budget);
        int n = 0;
        while (log_addr.size() < nw && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("write_timeout", 32'(log_addr.size() >= nw), 32'd1);
    endtask

    // expected stream: word i read from src+2i lands at dst+2i
    task automatic check_log(input logic [15:0] src, input logic [15:0] dst,
                             input int n);
        logic [15:0] sa;
        logic [15:0] da;
        check("nwrites", 32'(log_addr.size()), 32'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            sa = src + 16'(2 * i);
            da = dst + 16'(2 * i);
            check("waddr", 32'(log_addr[i]), 32'(da));
            check("wdata", 32'(log_data[i]), 32'(mem[sa[15:1]]));
        end
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] d;
        int          n;
        logic        saw_req;

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        reset          = 1'b0;
        m_grant        = 1'b1;
        reg_read_addr  = 16'h0000;
        reg_write_addr = 16'h0000;
        reg_write_data = 16'h0000;
        reg_write_en   = 2'b00;

        repeat (2) @(negedge clk);
        check("rst_out", {m_req, done_int, m_write_en, m_read_addr, 12'h000},
              32'h0);
        check("rst_wr", {m_write_addr, m_write_data}, 32'h0);
        check("rst_rdata", 32'(reg_read_data), 32'h0);
        reset = 1'b1;
        rd_chk("rst_ctrl", A_CTRL, 16'h0000);
        rd_chk("rst_cnt", A_CNT, 16'h0000);

        // register window: bytes, lsb forcing, unmapped
        wr(A_SRC, 16'h1235);
        rd_chk("src_lsb", A_SRC, 16'h1234);
        wr(A_SRC, 16'hAB99, 2'b10);
        rd_chk("src_hi_byte", A_SRC, 16'hAB34);
        wr(16'h0033, 16'h4321);
        rd_chk("src_odd_addr", A_SRC, 16'h4320);
        wr(A_CNT, 16'h5566);
        rd_chk("unmapped_38", 16'h0038, 16'h0000);
        rd_chk("unmapped_2e", 16'h002E, 16'h0000);
        wr(A_CTRL, 16'h0010);
        rd_chk("abort_idle", A_CTRL, 16'h0000);

        // basic copy with timing of m_req and done_int
        wr(A_SRC, 16'h2000);
        wr(A_DST, 16'h2100);
        wr(A_CNT, 16'd3);
        wr(A_CTRL, 16'h0005);
        check("req_rise", 32'(m_req), 32'd1);
        repeat (7) @(negedge clk);
        check("fin_req", {m_req, done_int}, 32'd0);
        @(negedge clk);
        check("irq_cycle9", 32'(done_int), 32'd1);
        check_log(16'h2000, 16'h2100, 3);
        rd_chk("basic_cnt", A_CNT, 16'h0000);
        rd_chk("basic_src", A_SRC, 16'h2006);
        rd_chk("basic_ctrl", A_CTRL, 16'h000C);
        wr(A_CTRL, 16'h000C);
        check("irq_clear", 32'(done_int), 32'd0);

        // COUNT=0 start completes with no bus activity
        wr(A_CNT, 16'd0);
        wr(A_CTRL, 16'h0005);
        check("cnt0_done", {m_req, done_int}, 32'd1);
        saw_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_req |= m_req;
        end
        check("cnt0_noreq", 32'(saw_req), 32'd0);
        check("cnt0_nowr", 32'(log_addr.size()), 32'd0);
        wr(A_CTRL, 16'h000C);

        // source wraps past 16'hFFFE
        wr(A_SRC, 16'hFFFE);
        wr(A_DST, 16'h5000);
        wr(A_CNT, 16'd2);
        wr(A_CTRL, 16'h0005);
        wait_irq(100);
        check_log(16'hFFFE, 16'h5000, 2);
        rd_chk("wrap_src", A_SRC, 16'h0002);
        wr(A_CTRL, 16'h000C);

        // grant loss during word 2
        wr(A_SRC, 16'h2200);
        wr(A_DST, 16'h9000);
        wr(A_CNT, 16'd3);
        wr(A_CTRL, 16'h0005);
        wait_writes(1, 50);
        @(negedge clk);
        m_grant = 1'b0;
        @(negedge clk);
        #1;
        check("gl_word2", 32'(log_addr.size()), 32'd2);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("gl_hold", {m_req, m_write_en}, 32'h4);
        end
        m_grant = 1'b1;
        wait_irq(100);
        check_log(16'h2200, 16'h9000, 3);
        wr(A_CTRL, 16'h000C);

        // abort after word 2 of 8
        wr(A_SRC, 16'h2400);
        wr(A_DST, 16'h9800);
        wr(A_CNT, 16'd8);
        wr(A_CTRL, 16'h0005);
        wait_writes(2, 50);
        reg_write_addr = A_CTRL;
        reg_write_data = 16'h0014;
        reg_write_en   = 2'b11;
        @(negedge clk);
        reg_write_en   = 2'b00;
        wait_irq(100);
        check_log(16'h2400, 16'h9800, 3);
        rd_chk("abort_cnt", A_CNT, 16'd5);
        rd_chk("abort_ctrl", A_CTRL, 16'h000C);
        wr(A_CTRL, 16'h000C);

        // busy protection and done-clear in the FIN cycle
        wr(A_SRC, 16'h2600);
        wr(A_DST, 16'hA000);
        wr(A_CNT, 16'd4);
        @(negedge clk);
        reg_write_addr = A_CTRL;
        reg_write_data = 16'h0005;
        reg_write_en   = 2'b11;
        @(negedge clk);
        check("bp_req", 32'(m_req), 32'd1);
        reg_write_addr = A_DST;
        reg_write_data = 16'h3000;
        @(negedge clk);
        reg_write_addr = A_CTRL;
        reg_write_data = 16'h0005;
        @(negedge clk);
        reg_write_en   = 2'b00;
        repeat (7) @(negedge clk);
        check("bp_fin", {m_req, done_int}, 32'd0);
        reg_write_addr = A_CTRL;
        reg_write_data = 16'h000C;
        reg_write_en   = 2'b11;
        @(negedge clk);
        reg_write_en   = 2'b00;
        check("bp_done_wins", 32'(done_int), 32'd1);
        check_log(16'h2600, 16'hA000, 4);
        rd_chk("bp_dst", A_DST, 16'hA008);
        rd_chk("bp_ctrl", A_CTRL, 16'h000C);
        repeat (3) @(negedge clk);
        check("bp_no_restart", 32'(m_req), 32'd0);
        wr(A_CTRL, 16'h000C);

        // randomized transfers, every other one with a flaky grant
        for (int t = 0; t < 8; t++) begin
            s = 16'h1000 + 16'(2 * $urandom_range(0, 16'h17FF));
            d = 16'h8000 + 16'(2 * $urandom_range(0, 16'h1FFF));
            n = $urandom_range(1, 6);
            wr(A_SRC, s);
            wr(A_DST, d);
            wr(A_CNT, 16'(n));
            wr(A_CTRL, 16'h0005);
            rgrant = t[0];
            wait_irq(400);
            rgrant = 1'b0;
            check_log(s, d, n);
            rd_chk("rnd_cnt", A_CNT, 16'h0000);
            rd_chk("rnd_src", A_SRC, s + 16'(2 * n));
            rd_chk("rnd_dst", A_DST, d + 16'(2 * n));
            rd_chk("rnd_ctrl", A_CTRL, 16'h000C);
            wr(A_CTRL, 16'h0008);
            check("rnd_irq_off", 32'(done_int), 32'd0);
            rd_chk("rnd_ctrl_clr", A_CTRL, 16'h0000);
        end

        // asynchronous reset mid-transfer
        wr(A_SRC, 16'h2800);
        wr(A_DST, 16'hB000);
        wr(A_CNT, 16'd6);
        wr(A_CTRL, 16'h0005);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out", {m_req, done_int, m_write_en, m_read_addr, 12'h000},
              32'h0);
        check("arst_wr", {m_write_addr, m_write_data}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk("arst_cnt", A_CNT, 16'h0000);
        rd_chk("arst_ctrl", A_CTRL, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
